// File: rtl/frame_opcode_assembler_if.sv
// Symbol-in / framed-word-out bundle of frame_opcode_assembler.
// master drives the symbol stream, slave (the assembler) drives the framed words and status.
interface frame_opcode_assembler_if #(
  parameter int DIN_W  = 4,
  parameter int DOUT_W = 8
);
  logic [DIN_W-1:0]  din;
  logic              din_vld;
  logic [DOUT_W-1:0] dout;
  logic              dout_vld;
  logic              dout_sop;
  logic              dout_eop;
  logic              sync_hit;
  logic              frame_err;
  logic [15:0]       frame_cnt;

  modport master (
    output din, din_vld,
    input  dout, dout_vld, dout_sop, dout_eop, sync_hit, frame_err, frame_cnt
  );

  modport slave (
    input  din, din_vld,
    output dout, dout_vld, dout_sop, dout_eop, sync_hit, frame_err, frame_cnt
  );
endinterface

// File: rtl/frame_opcode_assembler.sv
// Hunts a SYNC_PAT preamble in a DIN_W symbol stream, then packs PAYLOAD_WORDS DOUT_W words MSB-first
// with sop/eop; word out 1 clk after its last symbol; no backpressure. FRAME_TIMEOUT_EN adds a gap abort.
module frame_opcode_assembler #(
  parameter int                DIN_W         = 4,
  parameter int                SYNC_W        = 16,
  parameter logic [SYNC_W-1:0] SYNC_PAT      = 16'h55d5,
  parameter int                DOUT_W        = 8,
  parameter int                PAYLOAD_WORDS = 2,
  parameter int                TIMEOUT_CYC   = 256
) (
  input logic                   clk,
  input logic                   rst,
  frame_opcode_assembler_if.slave bus
);
  localparam int SYMS    = DOUT_W / DIN_W;
  localparam int SYM_CW  = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int WORD_CW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

  if ((DOUT_W % DIN_W) != 0 || (SYNC_W % DIN_W) != 0 || PAYLOAD_WORDS < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("frame_opcode_assembler: illegal parameter combination");
  end

  typedef enum logic {HUNT, PAYLOAD} state_t;
  state_t state, state_nxt;

  logic [SYNC_W-1:0]       sreg;
  logic [SYNC_W+DIN_W-1:0] sreg_ext;
  logic [DOUT_W-1:0]       shadow;
  logic [DOUT_W+DIN_W-1:0] word_ext;
  logic [SYM_CW-1:0]       sym_cnt;
  logic [WORD_CW-1:0]      word_cnt;
  logic                    match, word_done, frame_done, abort;

  logic [DOUT_W-1:0] dout_q;
  logic              dout_vld_q, sop_q, eop_q, sync_hit_q, frame_err_q;
  logic [15:0]       frame_cnt_q;

  // Concatenate-then-truncate keeps the shift legal even when a word or preamble is one symbol wide.
  assign sreg_ext = {sreg, bus.din};
  assign word_ext = {shadow, bus.din};

`ifdef FRAME_TIMEOUT_EN
  localparam int GAP_CW = $clog2(TIMEOUT_CYC);
  logic [GAP_CW-1:0] gap_cnt;

  assign abort = (state == PAYLOAD) && !bus.din_vld && (gap_cnt == GAP_CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 gap_cnt <= '0;
    else if (state != PAYLOAD || bus.din_vld) gap_cnt <= '0;
    else                                     gap_cnt <= gap_cnt + 1'b1;
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    match      = 1'b0;
    word_done  = 1'b0;
    frame_done = 1'b0;
    case (state)
      HUNT: begin
        if (bus.din_vld && sreg_ext[SYNC_W-1:0] == SYNC_PAT) begin
          match     = 1'b1;
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (bus.din_vld && sym_cnt == SYM_CW'(SYMS - 1)) begin
          word_done = 1'b1;
          if (word_cnt == WORD_CW'(PAYLOAD_WORDS - 1)) begin
            frame_done = 1'b1;
            state_nxt  = HUNT;
          end
        end
        if (abort) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg        <= '0;
      shadow      <= '0;
      sym_cnt     <= '0;
      word_cnt    <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      sync_hit_q  <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      dout_vld_q  <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      sync_hit_q  <= match;
      frame_err_q <= abort;
      if (state == HUNT) begin
        sym_cnt  <= '0;
        word_cnt <= '0;
        if (bus.din_vld) sreg <= sreg_ext[SYNC_W-1:0];
      end else if (abort) begin
        // Partial word is dropped; counters re-zero on the next HUNT cycle.
        sreg <= '0;
      end else if (bus.din_vld) begin
        shadow <= word_ext[DOUT_W-1:0];
        if (word_done) begin
          sym_cnt    <= '0;
          dout_q     <= word_ext[DOUT_W-1:0];
          dout_vld_q <= 1'b1;
          sop_q      <= (word_cnt == '0);
          eop_q      <= frame_done;
          if (frame_done) begin
            word_cnt    <= '0;
            sreg        <= '0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end else begin
          sym_cnt <= sym_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = dout_vld_q;
  assign bus.dout_sop  = sop_q;
  assign bus.dout_eop  = eop_q;
  assign bus.sync_hit  = sync_hit_q;
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_frame_opcode_assembler.sv
// Directed bench for frame_opcode_assembler: nibble instance (a) and byte-in/32-bit-out instance (b),
// expected words queued at drive time and compared with 1-clk latency when dout_vld appears.
module tb_frame_opcode_assembler;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  frame_opcode_assembler_if #(.DIN_W(4), .DOUT_W(8))  bus_a ();
  frame_opcode_assembler_if #(.DIN_W(8), .DOUT_W(32)) bus_b ();

  frame_opcode_assembler #(
    .DIN_W(4), .SYNC_W(16), .SYNC_PAT(16'h55d5), .DOUT_W(8), .PAYLOAD_WORDS(2), .TIMEOUT_CYC(8)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  frame_opcode_assembler #(
    .DIN_W(8), .SYNC_W(16), .SYNC_PAT(16'hAA55), .DOUT_W(32), .PAYLOAD_WORDS(1), .TIMEOUT_CYC(8)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  typedef struct {
    logic [31:0] word;
    logic        sop;
    logic        eop;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   sync_a = 0, err_a = 0, sync_b = 0;
  int   exp_sync = 0, exp_fc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.sync_hit === 1'b1)  sync_a++;
    if (bus_a.frame_err === 1'b1) err_a++;
    if (bus_a.dout_vld === 1'b1) begin
      check("a_word_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e_a = q_a.pop_front();
        check("a_dout", bus_a.dout, e_a.word);
        check("a_sop", bus_a.dout_sop, e_a.sop);
        check("a_eop", bus_a.dout_eop, e_a.eop);
        check("a_latency", cyc, e_a.cyc + 1);
      end
    end else if (bus_a.dout_sop !== 1'b0 || bus_a.dout_eop !== 1'b0) begin
      check("a_stray_tag", {bus_a.dout_sop, bus_a.dout_eop}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (bus_b.sync_hit === 1'b1) sync_b++;
    if (bus_b.dout_vld === 1'b1) begin
      check("b_word_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e_b = q_b.pop_front();
        check("b_dout", bus_b.dout, e_b.word);
        check("b_sop", bus_b.dout_sop, e_b.sop);
        check("b_eop", bus_b.dout_eop, e_b.eop);
        check("b_latency", cyc, e_b.cyc + 1);
      end
    end
  end

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      bus_a.din     = 4'($urandom);
      bus_a.din_vld = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic sym_a(input logic [3:0] d, input int idle);
    idle_a(idle);
    bus_a.din     = d;
    bus_a.din_vld = 1'b1;
    @(posedge clk); #1;
    bus_a.din_vld = 1'b0;
  endtask

  task automatic pre_a(input int idle);
    sym_a(4'h5, idle);
    sym_a(4'h5, idle);
    sym_a(4'hD, idle);
    sym_a(4'h5, idle);
    exp_sync++;
  endtask

  task automatic word_a(input logic [7:0] w, input logic sop, input logic eop, input int idle);
    exp_t e;
    sym_a(w[7:4], idle);
    idle_a(idle);
    e.word = 32'(w);
    e.sop  = sop;
    e.eop  = eop;
    e.cyc  = cyc;
    q_a.push_back(e);
    bus_a.din     = w[3:0];
    bus_a.din_vld = 1'b1;
    @(posedge clk); #1;
    bus_a.din_vld = 1'b0;
    if (eop) exp_fc++;
  endtask

  task automatic sym_b(input logic [7:0] d);
    bus_b.din     = d;
    bus_b.din_vld = 1'b1;
    @(posedge clk); #1;
    bus_b.din_vld = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, bus_a.dout, 32'd0);
    check({tag, "_dout_vld"}, bus_a.dout_vld, 32'd0);
    check({tag, "_sop_eop"}, {bus_a.dout_sop, bus_a.dout_eop}, 32'd0);
    check({tag, "_sync_hit"}, bus_a.sync_hit, 32'd0);
    check({tag, "_frame_err"}, bus_a.frame_err, 32'd0);
    check({tag, "_frame_cnt"}, bus_a.frame_cnt, 32'd0);
  endtask

  initial begin
    exp_t eb;
    rst           = 1'b1;
    bus_a.din     = '0;
    bus_a.din_vld = 1'b0;
    bus_b.din     = '0;
    bus_b.din_vld = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_b_dout", bus_b.dout, 32'd0);
    check("reset_b_frame_cnt", bus_b.frame_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_a(2);

    // Back-to-back symbols: 5,5,D,5,1,2,3,4
    pre_a(0);
    @(negedge clk);
    check("t1_sync_hit_pulse", bus_a.sync_hit, 32'd1);
    word_a(8'h12, 1'b1, 1'b0, 0);
    word_a(8'h34, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("t1_frame_cnt", bus_a.frame_cnt, exp_fc);
    idle_a(3);
    @(negedge clk);
    check("t1_dout_hold", bus_a.dout, 32'h34);
    check("t1_vld_single", bus_a.dout_vld, 32'd0);

    // One valid symbol every third clock, with leading symbols 0,5,5
    sym_a(4'h0, 2);
    sym_a(4'h5, 2);
    sym_a(4'h5, 2);
    pre_a(2);
    word_a(8'h12, 1'b1, 1'b0, 2);
    word_a(8'h34, 1'b0, 1'b1, 2);
    @(negedge clk);
    check("t2_frame_cnt", bus_a.frame_cnt, exp_fc);

    // Preamble pattern inside payload is plain data
    pre_a(0);
    word_a(8'h55, 1'b1, 1'b0, 0);
    word_a(8'hD5, 1'b0, 1'b1, 0);
    sym_a(4'hF, 0);
    pre_a(0);
    word_a(8'hAB, 1'b1, 1'b0, 0);
    word_a(8'hCD, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("t3_frame_cnt", bus_a.frame_cnt, exp_fc);
    check("t3_sync_count", sync_a, exp_sync);

`ifdef FRAME_TIMEOUT_EN
    // Gaps of 7 idle clocks survive the timeout
    pre_a(0);
    word_a(8'h12, 1'b1, 1'b0, 7);
    word_a(8'h34, 1'b0, 1'b1, 7);
    @(negedge clk);
    check("t4_gap7_no_err", err_a, 32'd0);
    check("t4_gap7_frame_cnt", bus_a.frame_cnt, exp_fc);
    // Gap of 8 idle clocks aborts the frame
    pre_a(0);
    sym_a(4'h1, 0);
    idle_a(8);
    @(negedge clk);
    check("t4_frame_err_pulse", bus_a.frame_err, 32'd1);
    check("t4_frame_cnt_kept", bus_a.frame_cnt, exp_fc);
    idle_a(1);
    @(negedge clk);
    check("t4_frame_err_single", bus_a.frame_err, 32'd0);
    pre_a(0);
    word_a(8'h56, 1'b1, 1'b0, 0);
    word_a(8'h78, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("t4_recover_frame_cnt", bus_a.frame_cnt, exp_fc);
`else
    // Without timeout a long gap inside the frame is simply waited out
    pre_a(0);
    word_a(8'h12, 1'b1, 1'b0, 20);
    word_a(8'h34, 1'b0, 1'b1, 20);
    @(negedge clk);
    check("t4_long_gap_frame_cnt", bus_a.frame_cnt, exp_fc);
`endif

    // Reset after three payload symbols aborts the frame
    pre_a(0);
    word_a(8'h98, 1'b1, 1'b0, 0);
    sym_a(4'h7, 0);
    rst = 1'b1;
    exp_fc = 0;
    @(negedge clk);
    check_reset_outputs("t5_mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    pre_a(0);
    word_a(8'h98, 1'b1, 1'b0, 0);
    word_a(8'h76, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("t5_frame_cnt", bus_a.frame_cnt, exp_fc);

    // Byte symbols into a single 32-bit word
    sym_b(8'hAA);
    sym_b(8'h55);
    sym_b(8'hDE);
    sym_b(8'hAD);
    sym_b(8'hBE);
    eb.word = 32'hDEADBEEF;
    eb.sop  = 1'b1;
    eb.eop  = 1'b1;
    eb.cyc  = cyc;
    q_b.push_back(eb);
    sym_b(8'hEF);
    @(negedge clk);
    check("t6_frame_cnt", bus_b.frame_cnt, 32'd1);
    check("t6_sync_count", sync_b, 32'd1);

    idle_a(4);
    @(negedge clk);
    check("end_a_queue_empty", q_a.size(), 32'd0);
    check("end_b_queue_empty", q_b.size(), 32'd0);
    check("end_a_sync_count", sync_a, exp_sync);
`ifdef FRAME_TIMEOUT_EN
    check("end_a_err_count", err_a, 32'd1);
`else
    check("end_a_err_count", err_a, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
